mult_share_arbiter: RTL and testbench
=====================================

# mult_share_arbiter

Round-robin scheduler that shares one combinational unsigned array multiplier among NUM_REQ requesters. Each requester presents an operand pair on a valid/ready handshake. The block grants one requester at a time, registers the operands and waits MUL_CYCLES cycles for the multiplier to settle. It then returns the exact 2·WIDTH-bit product, tagged with the requester index, on a single valid/ready response port. It sits between the multiplier datapath and its client blocks.

## Interface
- WIDTH, 11, operand width in bits (unsigned)
- NUM_REQ, 4, number of requesters (≥2)
- MUL_CYCLES, 1, multicycle settle budget for the multiplier (≥1)
- IDW, $clog2(NUM_REQ), requester index width (derived, not overridden)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept; at most one bit high
- req_a  in  NUM_REQ·WIDTH  packed operand A; requester i at [i·WIDTH +: WIDTH]
- req_b  in  NUM_REQ·WIDTH  packed operand B, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of the requester that owns rsp_product
- rsp_product  out  2·WIDTH  exact unsigned A·B

## Operation
- FSM states: IDLE, MUL, RESP. Reset state is IDLE.
- IDLE:
  - Grant g = first asserted req_valid at or after pointer ptr, searching upward with wrap-around.
  - req_ready[g]=1 combinationally; all other ready bits are 0.
  - On handshake: capture a_q=req_a[g], b_q=req_b[g], id_q=g; set ptr←(g+1) mod NUM_REQ; set cnt←MUL_CYCLES−1; go to MUL.
  - With no valid request: stay in IDLE; ptr is unchanged.
- MUL:
  - The multiplier is driven only from a_q/b_q.
  - While cnt≠0, decrement cnt.
  - When cnt==0: rsp_product←product, rsp_id←id_q, rsp_valid←1, go to RESP.
- RESP:
  - Hold rsp_* stable until rsp_valid&&rsp_ready; then rsp_valid←0 and go to IDLE.
  - No new grant is issued in the handshake cycle.
- req_ready is all-zero in MUL and RESP, and whenever rst_n=0.
- Requesters may change req_valid and operands freely before their handshake. Only the handshake cycle is sampled.
- Arithmetic: full-precision unsigned product, zero-extended into 2·WIDTH bits; no truncation or saturation.
- Reset values: rsp_valid=0, rsp_id=0, rsp_product=0, req_ready=0, ptr=0, cnt=0, a_q=b_q=0.

## Timing
- Request handshake at cycle T. rsp_valid rises at T+1+MUL_CYCLES (T+2 at default).
- Response handshake at cycle R. The earliest next request handshake is R+1.
- Peak throughput: one product per MUL_CYCLES+2 cycles.
- Fairness: a continuously asserted requester waits at most NUM_REQ−1 grants.
- Reset mid-operation: an in-flight op is discarded. rsp_valid drops immediately (asynchronous) and the block returns to IDLE with ptr=0.
- rsp_ready high while rsp_valid=0 has no effect.

## Configuration
- MULT_SHARE_ZERO_SKIP_EN defined:
  - If req_a[g]==0 or req_b[g]==0 at handshake, MUL is bypassed.
  - At T+1 the block enters RESP with rsp_product=0 and rsp_id=g.
- Undefined: every request passes through MUL for the full MUL_CYCLES.
- Arbitration is identical either way.

## Structure
- Package mult_share_pkg holds:
  - state enum {IDLE, MUL, RESP}
  - default WIDTH/NUM_REQ/MUL_CYCLES constants
  - an index-width helper function
- Sub-module rr_arbiter(NUM_REQ): inputs req vector and ptr; outputs one-hot grant and encoded index.
- The block instantiates the team's existing parallel_multiplier_11_PPA_Kogge_Stone (width=WIDTH) as the shared multiplier.

## Test plan
- Single op: req 2 with A=2047, B=2047, rsp_ready=1 → req_ready[2] at T; rsp_valid at T+2; rsp_id=2; rsp_product=4190209.
- Round robin: all four valid continuously, rsp_ready=1 → grants in order 0,1,2,3,0. Check products for A=i+3, B=i+5.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_id/rsp_product stable; no req_ready asserted; next grant at R+1.
- MUL_CYCLES=3: A=1024, B=3 → rsp_valid at T+4 with 3072.
- Zero skip (macro defined): A=0, B=1500 → rsp_valid at T+1 with 0. Macro undefined → rsp_valid at T+2 with 0.
- Reset mid-MUL: assert rst_n=0 the cycle after the grant → rsp_valid=0 at once. After release, a req from 3 is granted with ptr=0 and returns the correct product.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the shared-multiplier scheduler.
package mult_share_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      RESP
   } state_t;

   localparam int unsigned DEF_WIDTH      = 11;
   localparam int unsigned DEF_NUM_REQ    = 4;
   localparam int unsigned DEF_MUL_CYCLES = 1;

   // Width needed to hold values 0..n-1, never below one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr, with wrap-around.
module rr_arbiter
   import mult_share_pkg::*;
#(
   parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
   localparam int unsigned IDW     = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     idx
);

   logic           found;
   logic [IDW-1:0] pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         pos = IDW'((32'(ptr) + off) % NUM_REQ);
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end

endmodule

// File: rtl/parallel_multiplier_11_PPA_Kogge_Stone.sv
// Combinational unsigned array multiplier: partial-product rows summed
// with Kogge-Stone parallel-prefix adders.
module parallel_multiplier_11_PPA_Kogge_Stone #(
   parameter int unsigned width = 11
) (
   input  logic [width-1:0]   a,
   input  logic [width-1:0]   b,
   output logic [2*width-1:0] product
);

   localparam int unsigned PW = 2 * width;

   function automatic logic [PW-1:0] ks_add(input logic [PW-1:0] x, input logic [PW-1:0] y);
      logic [PW-1:0] g;
      logic [PW-1:0] p;
      logic [PW-1:0] t;
      logic [PW-1:0] gn;
      logic [PW-1:0] pn;
      g = x & y;
      p = x ^ y;
      t = p;
      for (int unsigned d = 1; d < PW; d = d * 2) begin
         gn = g;
         pn = p;
         for (int unsigned i = d; i < PW; i++) begin
            gn[i] = g[i] | (p[i] & g[i-d]);
            pn[i] = p[i] & p[i-d];
         end
         g = gn;
         p = pn;
      end
      // g[i] is now the carry out of bits 0..i, i.e. the carry into bit i+1.
      return t ^ {g[PW-2:0], 1'b0};
   endfunction

   logic [PW-1:0] ext_a;
   logic [PW-1:0] acc;

   assign ext_a = {{width{1'b0}}, a};

   always_comb begin
      acc = '0;
      for (int unsigned r = 0; r < width; r++) begin
         if (b[r]) begin
            acc = ks_add(acc, ext_a << r);
         end
      end
   end

   assign product = acc;

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler sharing one multiplier among NUM_REQ requesters.
// Optional MULT_SHARE_ZERO_SKIP_EN: zero operands bypass the MUL wait.
module mult_share_arbiter
   import mult_share_pkg::*;
#(
   parameter  int unsigned WIDTH      = DEF_WIDTH,
   parameter  int unsigned NUM_REQ    = DEF_NUM_REQ,
   parameter  int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
   localparam int unsigned IDW        = idx_width(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [IDW-1:0]           rsp_id,
   output logic [2*WIDTH-1:0]       rsp_product
);

   localparam int unsigned CW = idx_width(MUL_CYCLES);

`ifdef MULT_SHARE_ZERO_SKIP_EN
   localparam bit ZERO_SKIP = 1'b1;
`else
   localparam bit ZERO_SKIP = 1'b0;
`endif

   state_t               state;
   logic [IDW-1:0]       ptr;
   logic [IDW-1:0]       ptr_nxt;
   logic [IDW-1:0]       g_idx;
   logic [IDW-1:0]       id_q;
   logic [NUM_REQ-1:0]   g_hot;
   logic [CW-1:0]        cnt;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [WIDTH-1:0]     a_sel;
   logic [WIDTH-1:0]     b_sel;
   logic [2*WIDTH-1:0]   prod;
   logic                 take;
   logic                 zero_op;

   rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (g_hot),
      .idx   (g_idx)
   );

   parallel_multiplier_11_PPA_Kogge_Stone #(
      .width(WIDTH)
   ) u_mul (
      .a       (a_q),
      .b       (b_q),
      .product (prod)
   );

   // Ready is gated by rst_n so it is low throughout reset, not just after an edge.
   assign req_ready = (rst_n && (state == IDLE)) ? g_hot : '0;
   assign take      = |req_ready;
   assign ptr_nxt   = (g_idx == IDW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (g_hot[i]) begin
            a_sel = req_a[i*WIDTH +: WIDTH];
            b_sel = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   assign zero_op = ZERO_SKIP && ((a_sel == '0) || (b_sel == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= '0;
         cnt         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  a_q  <= a_sel;
                  b_q  <= b_sel;
                  id_q <= g_idx;
                  ptr  <= ptr_nxt;
                  cnt  <= CW'(MUL_CYCLES - 1);
                  if (zero_op) begin
                     rsp_product <= '0;
                     rsp_id      <= g_idx;
                     rsp_valid   <= 1'b1;
                     state       <= RESP;
                  end else begin
                     state <= MUL;
                  end
               end
            end
            MUL: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rsp_product <= prod;
                  rsp_id      <= id_q;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: a grant/latency/product model feeds
// an expectation queue that a separate monitor drains.
module tb_mult_share_arbiter;

   localparam int unsigned W   = 11;
   localparam int unsigned N   = 4;
   localparam int unsigned MC  = 1;
   localparam int unsigned IDW = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_ready;
   logic [N*W-1:0]     req_a;
   logic [N*W-1:0]     req_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IDW-1:0]     rsp_id;
   logic [2*W-1:0]     rsp_product;

   logic [N-1:0]       req_valid3;
   logic [N-1:0]       req_ready3;
   logic [N*W-1:0]     req_a3;
   logic [N*W-1:0]     req_b3;
   logic               rsp_valid3;
   logic               rsp_ready3;
   logic [IDW-1:0]     rsp_id3;
   logic [2*W-1:0]     rsp_product3;

   always #5 clk = ~clk;

   mult_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .MUL_CYCLES(MC)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_product(rsp_product)
   );

   mult_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .MUL_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_a(req_a3), .req_b(req_b3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
      .rsp_id(rsp_id3), .rsp_product(rsp_product3)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] id;
      logic [63:0] prod;
      logic [31:0] at;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned m_ptr  = 0;
   bit          m_busy = 1'b0;
   int unsigned m_resp_cyc = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event did not occur within cycle budget (t=%0t)", name, $time);
   endtask

   // Reference model: grant selection, pointer, latency and product from the rules.
   initial begin
      forever begin
         int          g;
         int          i;
         int unsigned lat;
         logic [N-1:0]   er;
         logic [W-1:0]   av;
         logic [W-1:0]   bv;
         exp_t           e;
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            m_ptr  = 0;
            m_busy = 1'b0;
            exp_q.delete();
            check("ready_in_reset", 64'(req_ready), 64'd0);
         end else if (!m_busy) begin
            g  = -1;
            er = '0;
            for (int k = 0; k < N; k++) begin
               i = (m_ptr + k) % N;
               if (g < 0 && req_valid[i]) g = i;
            end
            if (g >= 0) er[g] = 1'b1;
            check("grant", 64'(req_ready), 64'(er));
            if (g >= 0) begin
               av  = req_a[g*W +: W];
               bv  = req_b[g*W +: W];
               lat = 1 + MC;
`ifdef MULT_SHARE_ZERO_SKIP_EN
               if (av == 0 || bv == 0) lat = 1;
`endif
               e.id   = 32'(g);
               e.prod = 64'(av) * 64'(bv);
               e.at   = cyc + lat;
               exp_q.push_back(e);
               m_busy     = 1'b1;
               m_resp_cyc = cyc + lat;
               m_ptr      = (g + 1) % N;
            end
         end else begin
            check("ready_while_busy", 64'(req_ready), 64'd0);
            if (cyc >= m_resp_cyc && rsp_ready) m_busy = 1'b0;
         end
      end
   end

   // Monitor: pop on each new response, check hold while stalled.
   initial begin
      bit   have;
      exp_t cur;
      have = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            check("rsp_valid_in_reset", 64'(rsp_valid), 64'd0);
            have = 1'b0;
         end else if (rsp_valid === 1'b1) begin
            if (!have) begin
               if (exp_q.size() == 0) begin
                  timeout_fail("unexpected_rsp");
               end else begin
                  cur = exp_q.pop_front();
                  check("rsp_id", 64'(rsp_id), 64'(cur.id));
                  check("rsp_product", 64'(rsp_product), cur.prod);
                  check("rsp_cycle", 64'(cyc), 64'(cur.at));
                  have = 1'b1;
               end
            end else begin
               check("hold_id", 64'(rsp_id), 64'(cur.id));
               check("hold_product", 64'(rsp_product), cur.prod);
            end
            if (rsp_ready) have = 1'b0;
         end else begin
            check("rsp_valid_known", 64'(rsp_valid), 64'd0);
            if (have) begin
               check("rsp_dropped_early", 64'd0, 64'd1);
               have = 1'b0;
            end
         end
      end
   end

   task automatic set_req(input int i, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
      req_valid[i]     = v;
      req_a[i*W +: W]  = a;
      req_b[i*W +: W]  = b;
   endtask

   task automatic wait_ready(input int i, output int unsigned t);
      bit ok = 1'b0;
      t = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (req_ready[i]) begin
            ok = 1'b1;
            t  = cyc;
            break;
         end
      end
      if (!ok) timeout_fail("wait_ready");
   endtask

   task automatic wait_rsp(output int unsigned t);
      bit ok = 1'b0;
      t = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            ok = 1'b1;
            t  = cyc;
            break;
         end
      end
      if (!ok) timeout_fail("wait_rsp");
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   function automatic logic [W-1:0] pick();
      int unsigned r;
      r = $urandom_range(0, 7);
      if (r == 0) return '0;
      if (r == 1) return '1;
      return W'($urandom_range(0, (1 << W) - 1));
   endfunction

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int unsigned t;
      int unsigned tr;
      int          order[$];
      int          budget;
      bit          ok;

      rst_n      = 1'b0;
      req_valid  = '1;
      req_a      = '0;
      req_b      = '0;
      rsp_ready  = 1'b0;
      req_valid3 = '0;
      req_a3     = '0;
      req_b3     = '0;
      rsp_ready3 = 1'b0;
      #12;
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_id", 64'(rsp_id), 64'd0);
      check("reset_rsp_product", 64'(rsp_product), 64'd0);
      check("reset_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      req_valid = '0;

      // Single op at the operand maximum.
      rsp_ready = 1'b1;
      set_req(2, 1'b1, 11'd2047, 11'd2047);
      wait_ready(2, t);
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(tr);
      check("single_latency", 64'(tr), 64'(t + 2));
      check("single_id", 64'(rsp_id), 64'd2);
      check("single_product", 64'(rsp_product), 64'd4190209);

      // Zero operand.
      @(posedge clk);
      #1 set_req(1, 1'b1, 11'd0, 11'd1500);
      wait_ready(1, t);
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(tr);
`ifdef MULT_SHARE_ZERO_SKIP_EN
      check("zero_latency", 64'(tr), 64'(t + 1));
`else
      check("zero_latency", 64'(tr), 64'(t + 2));
`endif
      check("zero_product", 64'(rsp_product), 64'd0);
      repeat (3) @(posedge clk);

      // Round robin from pointer 0 with all requesters active.
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, W'(i + 3), W'(i + 5));
      budget = 0;
      while (order.size() < 5 && budget < 40) begin
         @(negedge clk);
         budget++;
         for (int i = 0; i < N; i++) if (req_ready[i]) order.push_back(i);
      end
      @(posedge clk);
      #1 req_valid = '0;
      if (order.size() < 5) timeout_fail("rr_order");
      else for (int k = 0; k < 5; k++) check("rr_order", 64'(order[k]), 64'(k % N));
      repeat (6) @(posedge clk);

      // Backpressure with every requester waiting.
      #1 rsp_ready = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, pick(), pick());
      wait_rsp(tr);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1 req_valid = '0;
      repeat (6) @(posedge clk);

      // Randomized traffic with changing operands and stalls.
      for (int c = 0; c < 400; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) set_req(i, 1'($urandom_range(0, 1)), pick(), pick());
         rsp_ready = ($urandom_range(0, 9) < 7);
      end
      @(posedge clk);
      #1 req_valid = '0;
      rsp_ready = 1'b1;
      repeat (8) @(posedge clk);

      // Reset while a response is held.
      #1 rsp_ready = 1'b0;
      set_req(0, 1'b1, 11'd77, 11'd99);
      wait_ready(0, t);
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(tr);
      #1 rst_n = 1'b0;
      #1 check("async_drop_rsp_valid", 64'(rsp_valid), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rsp_ready = 1'b1;

      // Reset during MUL, then a lone request from 3 after release.
      set_req(1, 1'b1, 11'd500, 11'd600);
      wait_ready(1, t);
      @(posedge clk);
      #1 rst_n = 1'b0;
      set_req(2, 1'b1, 11'd5, 11'd6);
      #1 check("mul_reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("mul_reset_req_ready", 64'(req_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1 req_valid = '0;
      rst_n = 1'b1;
      set_req(3, 1'b1, 11'd1234, 11'd1111);
      wait_ready(3, t);
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(tr);
      check("post_reset_id", 64'(rsp_id), 64'd3);
      check("post_reset_product", 64'(rsp_product), 64'd1370974);
      repeat (3) @(posedge clk);

      // Three-cycle settle budget instance.
      #1 req_valid3[0] = 1'b1;
      req_a3[0 +: W] = 11'd1024;
      req_b3[0 +: W] = 11'd3;
      rsp_ready3 = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (req_ready3[0]) begin
            ok = 1'b1;
            t  = cyc;
         end
      end
      if (!ok) timeout_fail("mc3_grant");
      @(posedge clk);
      #1 req_valid3 = '0;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (rsp_valid3) begin
            ok = 1'b1;
            tr = cyc;
         end
      end
      if (!ok) timeout_fail("mc3_rsp");
      else begin
         check("mc3_latency", 64'(tr), 64'(t + 4));
         check("mc3_product", 64'(rsp_product3), 64'd3072);
         check("mc3_id", 64'(rsp_id3), 64'd0);
      end
      repeat (4) @(posedge clk);

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("model_idle", 64'(m_busy), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
